// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: byte width, divisor width and reset value, FIFO sizing.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package uart_pkg;

    localparam int UART_DBIT     = 8;    // received byte width
    localparam int UART_ADDR_W   = 4;    // FIFO address width
    localparam int UART_DVSR_W   = 11;   // baud divisor register width
    localparam int UART_DVSR_RST = 650;  // 100 MHz / (16 * 9600) - 1

    // FIFO depth for a given pointer width.
    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    localparam int UART_FIFO_DEPTH = fifo_depth(UART_ADDR_W);

endpackage

// File: rtl/rx_fifo_ctrl.sv
// Pointer/occupancy bookkeeping for the receive FIFO; storage lives in the parent.
// Latency: push/pop update pointers and count on the next rising edge; status decoded from registered count.
// Backpressure: push while full is refused (overrun_evt) unless a pop frees the slot in the same cycle; pop while empty is ignored.
//
// Ports: clk, reset_n (async active-low); push/pop requests; push_en (write strobe for storage),
//        overrun_evt (push refused); wr_ptr/rd_ptr storage addresses; count/full/empty status.
module rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int ADDR_W = UART_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    output logic              push_en,
    output logic              overrun_evt,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              pop_en;

    always_comb begin
        full  = (count_q == DEPTH);
        empty = (count_q == '0);

        pop_en = pop && !empty;
        // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
        push_en     = push && (!full || pop_en);
        overrun_evt = push && !push_en;

        wr_ptr_d = wr_ptr_q;
        if (push_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        case ({push_en, pop_en})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: programmable 16x baud tick, FWFT byte FIFO with pop handshake, sticky overrun flag.
// Latency: pushed byte visible on r_data one cycle after rx_done_tick; pop shows next head one cycle after rd_uart.
// Backpressure: none toward the receiver core; a byte arriving while full (no pop) is dropped and sets overrun.
//
// Ports: clk, reset_n (async active-low); dvsr_wr/dvsr_in divisor load; s_tick oversampling pulse out;
//        rx_done_tick/rx_din byte from receiver; rd_uart pop; r_data head byte; rx_empty/rx_full/rx_count status;
//        overrun sticky error, cleared by clr_err.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DBIT     = UART_DBIT,
    parameter int ADDR_W   = UART_ADDR_W,
    parameter int DVSR_W   = UART_DVSR_W,
    parameter int DVSR_RST = UART_DVSR_RST
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dvsr_wr,
    input  logic [DVSR_W-1:0] dvsr_in,
    output logic              s_tick,
    input  logic              rx_done_tick,
    input  logic [DBIT-1:0]   rx_din,
    input  logic              rd_uart,
    output logic [DBIT-1:0]   r_data,
    output logic              rx_empty,
    output logic              rx_full,
    output logic [ADDR_W:0]   rx_count,
    output logic              overrun,
    input  logic              clr_err
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    // ---------------- baud generator ----------------
    logic [DVSR_W-1:0] dvsr_q,     dvsr_d;
    logic [DVSR_W-1:0] tick_cnt_q, tick_cnt_d;

    always_comb begin
        s_tick = (tick_cnt_q == dvsr_q);
        dvsr_d = dvsr_wr ? dvsr_in : dvsr_q;

        // A divisor write restarts the period so the first new tick comes dvsr_in cycles later.
        if (dvsr_wr || s_tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + DVSR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dvsr_q     <= DVSR_W'(DVSR_RST);
            tick_cnt_q <= '0;
        end else begin
            dvsr_q     <= dvsr_d;
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // ---------------- receive FIFO ----------------
    logic              push_en;
    logic              overrun_evt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    rx_fifo_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_fifo_ctrl (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (rx_done_tick),
        .pop         (rd_uart),
        .push_en     (push_en),
        .overrun_evt (overrun_evt),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .count       (rx_count),
        .full        (rx_full),
        .empty       (rx_empty)
    );

    // Storage is deliberately not reset; r_data is meaningless while rx_empty is high.
    logic [DBIT-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr] <= rx_din;
        end
    end

    // First-word-fall-through: head is read straight from the registered read pointer.
    assign r_data = mem_q[rd_ptr];

    // ---------------- overrun flag ----------------
    logic overrun_q, overrun_d;

    always_comb begin
        // Set has priority over clear so a drop coinciding with clr_err is never lost.
        if (overrun_evt) begin
            overrun_d = 1'b1;
        end else if (clr_err) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dvsr_wr = 1'b0;
    logic [10:0] dvsr_in = '0;
    logic        s_tick;
    logic        rx_done_tick = 1'b0;
    logic [7:0]  rx_din = '0;
    logic        rd_uart = 1'b0;
    logic [7:0]  r_data;
    logic        rx_empty;
    logic        rx_full;
    logic [4:0]  rx_count;
    logic        overrun;
    logic        clr_err = 1'b0;

    int total = 0;
    int bad   = 0;

    // Scoreboard: bytes expected on r_data, in order, plus expected overrun flag.
    logic [7:0] exp_q[$];
    logic       exp_ovr = 1'b0;

    always #5 clk = ~clk;

    uart_rx_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .dvsr_wr      (dvsr_wr),
        .dvsr_in      (dvsr_in),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .rx_din       (rx_din),
        .rd_uart      (rd_uart),
        .r_data       (r_data),
        .rx_empty     (rx_empty),
        .rx_full      (rx_full),
        .rx_count     (rx_count),
        .overrun      (overrun),
        .clr_err      (clr_err)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse reset across two falling edges and clear the scoreboard.
    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        exp_q.delete();
        exp_ovr = 1'b0;
    endtask

    // One clock of stimulus starting at a falling edge; updates the scoreboard and
    // reports the head seen before the edge and the head the scoreboard expected.
    task automatic step(input logic push, input logic [7:0] b, input logic pop, input logic clr,
                        output logic [7:0] seen, output logic [7:0] expv, output logic popped);
        logic was_full;
        seen     = r_data;
        expv     = '0;
        popped   = 1'b0;
        was_full = (exp_q.size() == 16);
        if (pop && exp_q.size() > 0) begin
            popped = 1'b1;
            expv   = exp_q.pop_front();
        end
        if (push) begin
            if (!was_full || popped) exp_q.push_back(b);
            else                     exp_ovr = 1'b1;
        end else if (clr) begin
            exp_ovr = 1'b0;
        end
        rx_done_tick = push;
        rx_din       = b;
        rd_uart      = pop;
        clr_err      = clr;
        @(negedge clk);
        rx_done_tick = 1'b0;
        rd_uart      = 1'b0;
        clr_err      = 1'b0;
    endtask

    task automatic test_reset();
        int tq[$];
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", rx_empty); end
        total++; if (rx_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", rx_full); end
        total++; if (rx_count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", rx_count); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        total++; if (s_tick !== 1'b0) begin bad++; $display("FAIL reset_stick: got %b want 0", s_tick); end
        tq = '{650, 1301, 1952};
        reset_n = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            if (s_tick === 1'b1) begin
                total++;
                if (tq.size() == 0 || tq[0] != c) begin
                    bad++; $display("FAIL default_tick: tick at cycle %0d, want %0d", c, (tq.size() == 0) ? -1 : tq[0]);
                end
                if (tq.size() > 0) void'(tq.pop_front());
            end
            @(negedge clk);
        end
        total++; if (tq.size() != 0) begin bad++; $display("FAIL default_tick_missing: got %0d unseen ticks want 0", tq.size()); end
    endtask

    task automatic test_divisor();
        int tq[$];
        do_reset();
        for (int t = 104; t <= 140; t += 4) tq.push_back(t);
        for (int t = 142; t <= 160; t++) tq.push_back(t);
        for (int c = 0; c <= 160; c++) begin
            if (s_tick === 1'b1) begin
                total++;
                if (tq.size() == 0 || tq[0] != c) begin
                    bad++; $display("FAIL dvsr_tick: tick at cycle %0d, want %0d", c, (tq.size() == 0) ? -1 : tq[0]);
                end
                if (tq.size() > 0) void'(tq.pop_front());
            end
            dvsr_wr = (c == 100) || (c == 141);
            dvsr_in = (c == 100) ? 11'd3 : 11'd0;
            @(negedge clk);
        end
        dvsr_wr = 1'b0;
        total++; if (tq.size() != 0) begin bad++; $display("FAIL dvsr_tick_missing: got %0d unseen ticks want 0", tq.size()); end
    endtask

    task automatic test_push_pop();
        logic [7:0] s, e;
        logic p;
        do_reset();
        step(1'b1, 8'hA5, 1'b0, 1'b0, s, e, p);
        total++; if (rx_count !== 5'd1 || rx_empty !== 1'b0) begin bad++; $display("FAIL push1_status: got count=%0d empty=%b want 1/0", rx_count, rx_empty); end
        total++; if (r_data !== 8'hA5) begin bad++; $display("FAIL push1_data: got %h want a5", r_data); end
        step(1'b1, 8'h3C, 1'b0, 1'b0, s, e, p);
        total++; if (rx_count !== 5'd2) begin bad++; $display("FAIL push2_count: got %0d want 2", rx_count); end
        step(1'b0, 8'h00, 1'b1, 1'b0, s, e, p);
        total++; if (s !== e || s !== 8'hA5) begin bad++; $display("FAIL pop1_data: got %h want %h", s, e); end
        total++; if (rx_count !== 5'd1 || r_data !== 8'h3C) begin bad++; $display("FAIL pop1_next: got count=%0d data=%h want 1/3c", rx_count, r_data); end
        step(1'b0, 8'h00, 1'b1, 1'b0, s, e, p);
        total++; if (s !== e || s !== 8'h3C) begin bad++; $display("FAIL pop2_data: got %h want %h", s, e); end
        total++; if (rx_count !== 5'd0 || rx_empty !== 1'b1) begin bad++; $display("FAIL pop2_empty: got count=%0d empty=%b want 0/1", rx_count, rx_empty); end
        // Pop on empty is ignored; push+pop on empty only pushes.
        step(1'b0, 8'h00, 1'b1, 1'b0, s, e, p);
        total++; if (rx_count !== 5'd0 || rx_empty !== 1'b1) begin bad++; $display("FAIL pop_empty: got count=%0d empty=%b want 0/1", rx_count, rx_empty); end
        step(1'b1, 8'h77, 1'b1, 1'b0, s, e, p);
        total++; if (rx_count !== 5'd1 || r_data !== 8'h77) begin bad++; $display("FAIL pushpop_empty: got count=%0d data=%h want 1/77", rx_count, r_data); end
        step(1'b0, 8'h00, 1'b1, 1'b0, s, e, p);
        total++; if (s !== 8'h77 || rx_empty !== 1'b1) begin bad++; $display("FAIL pushpop_drain: got data=%h empty=%b want 77/1", s, rx_empty); end
    endtask

    task automatic test_fill_overrun();
        logic [7:0] s, e;
        logic p;
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, s, e, p);
            if (i == 15) begin
                total++; if (rx_full !== 1'b1 || rx_count !== 5'd16 || overrun !== 1'b0) begin
                    bad++; $display("FAIL fill16: got full=%b count=%0d ovr=%b want 1/16/0", rx_full, rx_count, overrun);
                end
            end
        end
        total++; if (overrun !== 1'b1 || rx_count !== 5'd16) begin bad++; $display("FAIL overrun_set: got ovr=%b count=%0d want 1/16", overrun, rx_count); end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, s, e, p);
            total++; if (s !== e || s !== 8'(i)) begin bad++; $display("FAIL drain_order: got %h want %h", s, 8'(i)); end
        end
        total++; if (rx_empty !== 1'b1 || overrun !== 1'b1) begin bad++; $display("FAIL drained: got empty=%b ovr=%b want 1/1", rx_empty, overrun); end
        step(1'b0, 8'h00, 1'b0, 1'b1, s, e, p);
        total++; if (overrun !== exp_ovr || overrun !== 1'b0) begin bad++; $display("FAIL clr_alone: got %b want 0", overrun); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] s, e;
        logic p;
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, s, e, p);
        step(1'b1, 8'h55, 1'b1, 1'b0, s, e, p);
        total++; if (s !== 8'h20) begin bad++; $display("FAIL full_pp_head: got %h want 20", s); end
        total++; if (overrun !== 1'b0 || rx_count !== 5'd16 || rx_full !== 1'b1) begin
            bad++; $display("FAIL full_pp_status: got ovr=%b count=%0d full=%b want 0/16/1", overrun, rx_count, rx_full);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, s, e, p);
            total++; if (s !== e) begin bad++; $display("FAIL full_pp_drain: got %h want %h", s, e); end
        end
        total++; if (s !== 8'h55 || rx_empty !== 1'b1) begin bad++; $display("FAIL full_pp_last: got %h empty=%b want 55/1", s, rx_empty); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s, e;
        logic p;
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, s, e, p);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'hD0 + i), 1'b1, 1'b0, s, e, p);
            total++; if (s !== e || rx_count !== 5'd3) begin bad++; $display("FAIL b2b: got data=%h count=%0d want %h/3", s, rx_count, e); end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, s, e, p);
            total++; if (s !== e || s !== 8'(8'hD5 + i)) begin bad++; $display("FAIL b2b_drain: got %h want %h", s, 8'(8'hD5 + i)); end
        end
    endtask

    task automatic test_overrun_clr_reset();
        logic [7:0] s, e;
        logic p;
        int first_tick;
        do_reset();
        dvsr_wr = 1'b1;
        dvsr_in = 11'd5;
        @(negedge clk);
        dvsr_wr = 1'b0;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, s, e, p);
        step(1'b1, 8'h99, 1'b0, 1'b1, s, e, p);
        total++; if (overrun !== exp_ovr || overrun !== 1'b1) begin bad++; $display("FAIL ovr_clr_same: got %b want 1", overrun); end
        step(1'b0, 8'h00, 1'b0, 1'b1, s, e, p);
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr_only: got %b want 0", overrun); end
        // Asynchronous reset mid-operation.
        step(1'b0, 8'h00, 1'b1, 1'b0, s, e, p);
        reset_n = 1'b0;
        #1;
        total++; if (rx_empty !== 1'b1 || rx_count !== 5'd0 || rx_full !== 1'b0) begin
            bad++; $display("FAIL async_reset: got empty=%b count=%0d full=%b want 1/0/0", rx_empty, rx_count, rx_full);
        end
        exp_q.delete();
        exp_ovr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        first_tick = -1;
        for (int c = 0; c <= 660; c++) begin
            if (s_tick === 1'b1 && first_tick < 0) first_tick = c;
            @(negedge clk);
        end
        total++; if (first_tick != 650) begin bad++; $display("FAIL dvsr_after_reset: first tick %0d want 650", first_tick); end
    endtask

    initial begin
        test_reset();
        test_divisor();
        test_push_pop();
        test_fill_overrun();
        test_full_push_pop();
        test_back_to_back();
        test_overrun_clr_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
